// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//
// Fetch stage sitting directly in front of control/decode. Holds the program
// counter and fetches one instruction at a time over a valid/ready
// instruction-memory port, with at most one request outstanding. The fetched
// word is held for decode until it is accepted. On acceptance the PC advances
// by 4, or by the decode-supplied branch offset when a branch is taken.
//
// Ports
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   imem_req_valid_o    fetch request valid (registered)
//   imem_req_addr_o     fetch address, always equal to the current PC
//   imem_req_ready_i    memory accepts the request this cycle
//   imem_rsp_valid_i    response word valid
//   imem_rsp_data_i     response instruction word
//   instr_o             held instruction presented to decode
//   pc_o                address of the held instruction
//   instr_valid_o       instr_o/pc_o valid for decode (registered)
//   instr_ready_i       decode consumes the held instruction this cycle
//   pc_src_i            1 = take branch, sampled only on the accept edge
//   imm_op_i            sign-extended branch offset, sampled on the accept edge
//   fetch_count_o       number of instructions accepted by decode (wraps)
// ----------------------------------------------------------------------------
module instr_fetch #(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,

    // Instruction-memory request channel
    output logic                     imem_req_valid_o,
    output logic [ADDRESS_WIDTH-1:0] imem_req_addr_o,
    input  logic                     imem_req_ready_i,

    // Instruction-memory response channel
    input  logic                     imem_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0]    imem_rsp_data_i,

    // Decode interface
    output logic [DATA_WIDTH-1:0]    instr_o,
    output logic [ADDRESS_WIDTH-1:0] pc_o,
    output logic                     instr_valid_o,
    input  logic                     instr_ready_i,
    input  logic                     pc_src_i,
    input  logic [ADDRESS_WIDTH-1:0] imm_op_i,

    // Statistics
    output logic [31:0]              fetch_count_o
);

    typedef enum logic [1:0] {
        StReq  = 2'd0,
        StWait = 2'd1,
        StHold = 2'd2
    } state_e;

    localparam logic [ADDRESS_WIDTH-1:0] PcStep     = ADDRESS_WIDTH'(4);
    localparam logic [ADDRESS_WIDTH-1:0] ResetPcAln = {RESET_PC[ADDRESS_WIDTH-1:2], 2'b00};

    state_e                     state_q;
    logic [ADDRESS_WIDTH-1:0]   pc_q;
    logic [DATA_WIDTH-1:0]      instr_q;
    logic                       instr_valid_q;
    logic                       req_valid_q;
    logic [31:0]                fetch_count_q;

    logic [ADDRESS_WIDTH-1:0]   pc_incr;
    logic [ADDRESS_WIDTH-1:0]   pc_sum;
    logic [ADDRESS_WIDTH-1:0]   next_pc;

    // Next PC wraps naturally at 2^ADDRESS_WIDTH; the low two bits are forced
    // to zero so a misaligned branch offset can never produce a misaligned
    // fetch address.
    always_comb begin
        pc_incr = pc_src_i ? imm_op_i : PcStep;
        pc_sum  = pc_q + pc_incr;
        next_pc = {pc_sum[ADDRESS_WIDTH-1:2], 2'b00};
    end

    // Single FSM process. The valid outputs are registered and set alongside
    // the state they belong to, so they always decode the current state.
    // Exception: after reset the request valid comes up one cycle late, since
    // it must read 0 while reset is asserted and is only a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StReq;
            pc_q          <= ResetPcAln;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            req_valid_q   <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            unique case (state_q)
                StReq: begin
                    // Handshake only counts once our valid is actually visible.
                    if (req_valid_q && imem_req_ready_i) begin
                        state_q     <= StWait;
                        req_valid_q <= 1'b0;
                    end else begin
                        req_valid_q <= 1'b1;
                    end
                end

                StWait: begin
                    if (imem_rsp_valid_i) begin
                        instr_q       <= imem_rsp_data_i;
                        instr_valid_q <= 1'b1;
                        state_q       <= StHold;
                    end
                end

                StHold: begin
                    // Backpressure simply parks here: no new request goes out
                    // until decode takes the held word.
                    if (instr_ready_i) begin
                        pc_q          <= next_pc;
                        fetch_count_q <= fetch_count_q + 32'd1;
                        instr_valid_q <= 1'b0;
                        req_valid_q   <= 1'b1;
                        state_q       <= StReq;
                    end
                end

                default: begin
                    state_q       <= StReq;
                    instr_valid_q <= 1'b0;
                    req_valid_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_valid_o = req_valid_q;
    assign imem_req_addr_o  = pc_q;
    assign instr_o          = instr_q;
    assign pc_o             = pc_q;
    assign instr_valid_o    = instr_valid_q;
    assign fetch_count_o    = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. dut0 uses RESET_PC=0 and carries most
// scenarios; dut1 uses RESET_PC=0xFFFFFFFC to exercise PC wrap-around.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;

    // dut0 signals
    logic        req_valid0;
    logic [31:0] req_addr0;
    logic        req_ready0;
    logic        rsp_valid0;
    logic [31:0] rsp_data0;
    logic [31:0] instr0;
    logic [31:0] pc0;
    logic        instr_valid0;
    logic        instr_ready0;
    logic        pc_src0;
    logic [31:0] imm0;
    logic [31:0] count0;

    // dut1 signals
    logic        rst1_n;
    logic        req_valid1;
    logic [31:0] req_addr1;
    logic        req_ready1;
    logic        rsp_valid1;
    logic [31:0] rsp_data1;
    logic [31:0] instr1;
    logic [31:0] pc1;
    logic        instr_valid1;
    logic        instr_ready1;
    logic        pc_src1;
    logic [31:0] imm1;
    logic [31:0] count1;

    int n_tests;
    int n_fail;

    instr_fetch #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH   (32),
        .RESET_PC     (32'h0000_0000)
    ) dut0 (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid_o(req_valid0),
        .imem_req_addr_o (req_addr0),
        .imem_req_ready_i(req_ready0),
        .imem_rsp_valid_i(rsp_valid0),
        .imem_rsp_data_i (rsp_data0),
        .instr_o         (instr0),
        .pc_o            (pc0),
        .instr_valid_o   (instr_valid0),
        .instr_ready_i   (instr_ready0),
        .pc_src_i        (pc_src0),
        .imm_op_i        (imm0),
        .fetch_count_o   (count0)
    );

    instr_fetch #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH   (32),
        .RESET_PC     (32'hFFFF_FFFC)
    ) dut1 (
        .clk             (clk),
        .rst_n           (rst1_n),
        .imem_req_valid_o(req_valid1),
        .imem_req_addr_o (req_addr1),
        .imem_req_ready_i(req_ready1),
        .imem_rsp_valid_i(rsp_valid1),
        .imem_rsp_data_i (rsp_data1),
        .instr_o         (instr1),
        .pc_o            (pc1),
        .instr_valid_o   (instr_valid1),
        .instr_ready_i   (instr_ready1),
        .pc_src_i        (pc_src1),
        .imm_op_i        (imm1),
        .fetch_count_o   (count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From StReq with req_valid high: handshake, then response next cycle.
    // Leaves dut0 in StHold.
    task automatic fetch0(input logic [31:0] data);
        req_ready0 = 1'b1;
        step();
        rsp_valid0 = 1'b1;
        rsp_data0  = data;
        step();
        rsp_valid0 = 1'b0;
    endtask

    // Accept the held instruction with the given branch inputs.
    task automatic accept0(input logic src, input logic [31:0] imm);
        instr_ready0 = 1'b1;
        pc_src0      = src;
        imm0         = imm;
        step();
        instr_ready0 = 1'b0;
        pc_src0      = 1'b0;
        imm0         = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rst1_n = 1'b0;
        step();
        step();
        n_tests++;
        if (req_valid0 !== 1'b0) begin
            n_fail++; $display("FAIL reset_req_valid: got %b want 0", req_valid0);
        end
        n_tests++;
        if (req_addr0 !== 32'h0 || pc0 !== 32'h0) begin
            n_fail++; $display("FAIL reset_pc: got addr %h pc %h want 0", req_addr0, pc0);
        end
        n_tests++;
        if (instr_valid0 !== 1'b0 || instr0 !== 32'h0 || count0 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got iv %b instr %h cnt %0d want 0/0/0",
                     instr_valid0, instr0, count0);
        end
        n_tests++;
        if (req_addr1 !== 32'hFFFF_FFFC || req_valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pc_dut1: got addr %h rv %b want fffffffc/0", req_addr1, req_valid1);
        end
        rst_n = 1'b1;
        rst1_n = 1'b1;
        req_ready0 = 1'b1;
        step();
        n_tests++;
        if (req_valid0 !== 1'b1 || req_addr0 !== 32'h0) begin
            n_fail++;
            $display("FAIL first_req: got rv %b addr %h want 1/00000000", req_valid0, req_addr0);
        end
    endtask

    task automatic test_first_fetch();
        step();  // handshake with req_ready0=1
        n_tests++;
        if (req_valid0 !== 1'b0 || instr_valid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_outputs: got rv %b iv %b want 0/0", req_valid0, instr_valid0);
        end
        rsp_valid0 = 1'b1;
        rsp_data0  = 32'h0050_0093;
        step();
        rsp_valid0 = 1'b0;
        n_tests++;
        if (instr_valid0 !== 1'b1 || instr0 !== 32'h0050_0093 || pc0 !== 32'h0) begin
            n_fail++;
            $display("FAIL first_hold: got iv %b instr %h pc %h want 1/00500093/0",
                     instr_valid0, instr0, pc0);
        end
        accept0(1'b0, 32'h0);
        n_tests++;
        if (req_valid0 !== 1'b1 || req_addr0 !== 32'h4 || count0 !== 32'd1
            || instr_valid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL first_accept: got rv %b addr %h cnt %0d iv %b want 1/4/1/0",
                     req_valid0, req_addr0, count0, instr_valid0);
        end
    endtask

    task automatic test_branch();
        fetch0(32'h0000_0013);
        accept0(1'b0, 32'h0);
        n_tests++;
        if (req_addr0 !== 32'h8 || count0 !== 32'd2) begin
            n_fail++; $display("FAIL seq_pc: got addr %h cnt %0d want 8/2", req_addr0, count0);
        end
        fetch0(32'hFE00_0CE3);
        n_tests++;
        if (pc0 !== 32'h8 || instr_valid0 !== 1'b1) begin
            n_fail++; $display("FAIL branch_hold: got pc %h iv %b want 8/1", pc0, instr_valid0);
        end
        accept0(1'b1, 32'hFFFF_FFF8);
        n_tests++;
        if (req_addr0 !== 32'h0 || count0 !== 32'd3 || req_valid0 !== 1'b1) begin
            n_fail++;
            $display("FAIL branch_back: got addr %h cnt %0d rv %b want 0/3/1",
                     req_addr0, count0, req_valid0);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        fetch0(32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            // Stray responses while holding must not disturb the held word.
            rsp_valid0 = (i % 2 == 0);
            rsp_data0  = 32'hDEAD_BEEF;
            step();
            if (instr_valid0 !== 1'b1 || instr0 !== 32'h1234_5678 || pc0 !== 32'h0
                || req_valid0 !== 1'b0 || count0 !== 32'd3) bad++;
        end
        rsp_valid0 = 1'b0;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_stable: got %0d bad cycles (iv %b instr %h pc %h rv %b) want 0",
                     bad, instr_valid0, instr0, pc0, req_valid0);
        end
        accept0(1'b0, 32'h0);
        n_tests++;
        if (count0 !== 32'd4 || req_addr0 !== 32'h4 || req_valid0 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_accept: got cnt %0d addr %h rv %b want 4/4/1",
                     count0, req_addr0, req_valid0);
        end
    endtask

    task automatic test_ignored_inputs();
        // In StReq with memory stalled: decode ready and stray responses do nothing.
        req_ready0   = 1'b0;
        instr_ready0 = 1'b1;
        pc_src0      = 1'b1;
        imm0         = 32'h100;
        rsp_valid0   = 1'b1;
        rsp_data0    = 32'hAAAA_5555;
        step();
        step();
        instr_ready0 = 1'b0;
        pc_src0      = 1'b0;
        imm0         = '0;
        rsp_valid0   = 1'b0;
        n_tests++;
        if (req_valid0 !== 1'b1 || req_addr0 !== 32'h4 || count0 !== 32'd4
            || instr_valid0 !== 1'b0 || instr0 !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL ignore_in_req: got rv %b addr %h cnt %0d iv %b instr %h want 1/4/4/0/12345678",
                     req_valid0, req_addr0, count0, instr_valid0, instr0);
        end
        // In StWait: decode ready still ignored.
        req_ready0 = 1'b1;
        step();
        instr_ready0 = 1'b1;
        step();
        instr_ready0 = 1'b0;
        n_tests++;
        if (pc0 !== 32'h4 || count0 !== 32'd4 || req_valid0 !== 1'b0 || instr_valid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_in_wait: got pc %h cnt %0d rv %b iv %b want 4/4/0/0",
                     pc0, count0, req_valid0, instr_valid0);
        end
        rsp_valid0 = 1'b1;
        rsp_data0  = 32'h0000_0033;
        step();
        rsp_valid0 = 1'b0;
        // Misaligned offset: 0x4 + 0x6 = 0xA, low bits cleared -> 0x8.
        accept0(1'b1, 32'h0000_0006);
        n_tests++;
        if (req_addr0 !== 32'h8 || count0 !== 32'd5) begin
            n_fail++; $display("FAIL align_pc: got addr %h cnt %0d want 8/5", req_addr0, count0);
        end
    endtask

    task automatic test_pc_wrap();
        n_tests++;
        if (req_valid1 !== 1'b1 || req_addr1 !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_first_req: got rv %b addr %h want 1/fffffffc", req_valid1, req_addr1);
        end
        req_ready1 = 1'b1;
        step();
        req_ready1 = 1'b0;
        rsp_valid1 = 1'b1;
        rsp_data1  = 32'h0000_006F;
        step();
        rsp_valid1 = 1'b0;
        n_tests++;
        if (instr_valid1 !== 1'b1 || pc1 !== 32'hFFFF_FFFC || instr1 !== 32'h0000_006F) begin
            n_fail++;
            $display("FAIL wrap_hold: got iv %b pc %h instr %h want 1/fffffffc/0000006f",
                     instr_valid1, pc1, instr1);
        end
        instr_ready1 = 1'b1;
        step();
        instr_ready1 = 1'b0;
        n_tests++;
        if (req_addr1 !== 32'h0 || count1 !== 32'd1 || req_valid1 !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_next: got addr %h cnt %0d rv %b want 0/1/1",
                     req_addr1, count1, req_valid1);
        end
    endtask

    task automatic test_reset_mid();
        // dut0 sits in StReq at 0x8 with count 5; issue the request -> StWait.
        req_ready0 = 1'b1;
        step();
        n_tests++;
        if (req_valid0 !== 1'b0 || pc0 !== 32'h8) begin
            n_fail++; $display("FAIL pre_reset_wait: got rv %b pc %h want 0/8", req_valid0, pc0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (req_valid0 !== 1'b0 || pc0 !== 32'h0 || count0 !== 32'd0 || instr0 !== 32'h0
            || instr_valid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got rv %b pc %h cnt %0d instr %h iv %b want 0/0/0/0/0",
                     req_valid0, pc0, count0, instr0, instr_valid0);
        end
        step();
        rst_n = 1'b1;
        step();
        n_tests++;
        if (req_valid0 !== 1'b1 || req_addr0 !== 32'h0 || count0 !== 32'd0) begin
            n_fail++;
            $display("FAIL post_reset_req: got rv %b addr %h cnt %0d want 1/0/0",
                     req_valid0, req_addr0, count0);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;  rst1_n = 1'b0;
        req_ready0 = 1'b0; rsp_valid0 = 1'b0; rsp_data0 = '0;
        instr_ready0 = 1'b0; pc_src0 = 1'b0; imm0 = '0;
        req_ready1 = 1'b0; rsp_valid1 = 1'b0; rsp_data1 = '0;
        instr_ready1 = 1'b0; pc_src1 = 1'b0; imm1 = '0;
        #2;
        test_reset();
        test_first_fetch();
        test_branch();
        test_backpressure();
        test_ignored_inputs();
        test_pc_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
